// File: rtl/wb_ctrl.sv
// wb_ctrl: CNN output write-back sequencer.
// Packs 5-byte beats from the PE groups into 16-byte pairs and writes them to
// BRAM32k as two 64-bit words at consecutive addresses from a per-layer base.
// The partial tail is flushed zero-padded at layer end, then layer_done pulses.
// Optional feature macro: WB_OVF_CHECK_EN (adds ovf_err, suppresses writes that
// would run past the top of the address space).
module wb_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_start,
  input  logic [3:0]        Layer,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       out_count,
  input  logic              sum_valid,
  input  logic [7:0]        sum1,
  input  logic [7:0]        sum2,
  input  logic [7:0]        sum3,
  input  logic [7:0]        sum4,
  input  logic [7:0]        sum5,
  output logic              sum_ready,
  output logic              we_BRAM32k,
  output logic [ADDR_W-1:0] addr_BRAM32k_1,
  output logic [ADDR_W-1:0] addr_BRAM32k_2,
  output logic [63:0]       din_BRAM32k_1,
  output logic [63:0]       din_BRAM32k_2,
  output logic              busy,
`ifdef WB_OVF_CHECK_EN
  output logic              ovf_err,
`endif
  output logic              layer_done
);

  localparam int NSUM  = 5;
  localparam int BUF_N = 24;
  localparam int KW    = 13;           // pair index: up to 4096 pairs per layer
  localparam int FW    = ADDR_W + KW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_n;

  logic [BUF_N-1:0][7:0] bytes_q, bytes_n;
  logic [NSUM-1:0][7:0]  sums;
  logic [15:0][7:0]      pair;
  logic [4:0]            cnt_q, cnt_n, base_cnt;
  logic [15:0]           recv_q, recv_n, out_q, rem;
  logic [2:0]            taken;
  logic [KW-1:0]         k_q;
  logic [ADDR_W-1:0]     base_q, wr_addr;
  logic [FW-1:0]         addr_full;
  logic [3:0]            layer_q;
  logic                  start_ok, accept, full_wr, tail_wr, wr_fire, ovf_hit;

  assign sums      = {sum5, sum4, sum3, sum2, sum1};
  // The cycle layer_done is high still counts as part of the finishing layer.
  assign start_ok  = (state_q == IDLE) && layer_start && !layer_done;
  assign rem       = out_q - recv_q;
  assign taken     = (rem >= 16'(NSUM)) ? 3'(NSUM) : rem[2:0];
  assign accept    = sum_ready && sum_valid;
  assign full_wr   = ((state_q == RUN) || (state_q == FLUSH)) && (cnt_q >= 5'd16);
  assign tail_wr   = (state_q == FLUSH) && (cnt_q != 5'd0) && (cnt_q < 5'd16);
  assign wr_fire   = full_wr || tail_wr;
  assign addr_full = FW'(base_q) + FW'({k_q, 1'b0});
  assign wr_addr   = addr_full[ADDR_W-1:0];

`ifdef WB_OVF_CHECK_EN
  // Pair's second word would land past the last address.
  assign ovf_hit = addr_full >= FW'((2 ** ADDR_W) - 1);
`else
  logic unused_addr_hi;
  assign ovf_hit        = 1'b0;
  assign unused_addr_hi = ^addr_full[FW-1:ADDR_W];
`endif

  // Layer number is latched for debug visibility only.
  logic unused_layer;
  assign unused_layer = ^layer_q;

  // Buffer update: drop the written pair first, then append accepted bytes behind what is left.
  always_comb begin
    bytes_n  = bytes_q;
    base_cnt = cnt_q;
    recv_n   = recv_q;
    if (full_wr) begin
      bytes_n  = {128'b0, bytes_q[BUF_N-1:16]};
      base_cnt = cnt_q - 5'd16;
    end
    if (accept) begin
      for (int j = 0; j < BUF_N; j++)
        for (int i = 0; i < NSUM; i++)
          if ((3'(i) < taken) && (5'(j) == base_cnt + 5'(i))) bytes_n[j] = sums[i];
      recv_n = recv_q + 16'(taken);
    end
    cnt_n = accept ? base_cnt + 5'(taken) : base_cnt;
    if (tail_wr) cnt_n = 5'd0;
  end

  // Write payload: bytes beyond the valid count go out as zero (only matters for the tail).
  always_comb begin
    pair = '0;
    for (int b = 0; b < 16; b++)
      if (5'(b) < cnt_q) pair[b] = bytes_q[b];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next state. RUN leaves as soon as the post-edge view has every byte in and no full pair pending,
  // so a write on the leaving edge is followed directly by the flush step.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_n = (out_count == 16'd0) ? FLUSH : RUN;
      RUN:     if ((recv_n == out_q) && (cnt_n < 5'd16)) state_n = FLUSH;
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    sum_ready = (state_q == RUN) && (recv_q < out_q);
    busy      = (state_q != IDLE);
  end

  // Layer config latch, byte buffer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_q <= '0;
      cnt_q   <= '0;
      recv_q  <= '0;
      k_q     <= '0;
      out_q   <= '0;
      base_q  <= '0;
      layer_q <= '0;
    end else if (start_ok) begin
      cnt_q   <= '0;
      recv_q  <= '0;
      k_q     <= '0;
      out_q   <= out_count;
      base_q  <= base_addr;
      layer_q <= Layer;
    end else begin
      bytes_q <= bytes_n;
      cnt_q   <= cnt_n;
      recv_q  <= recv_n;
      if (wr_fire) k_q <= k_q + KW'(1);
    end
  end

  // BRAM port registers: one-cycle enable, address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_BRAM32k     <= 1'b0;
      addr_BRAM32k_1 <= '0;
      addr_BRAM32k_2 <= '0;
      din_BRAM32k_1  <= '0;
      din_BRAM32k_2  <= '0;
    end else begin
      we_BRAM32k <= wr_fire && !ovf_hit;
      if (wr_fire && !ovf_hit) begin
        addr_BRAM32k_1 <= wr_addr;
        addr_BRAM32k_2 <= wr_addr + ADDR_W'(1);
        din_BRAM32k_1  <= pair[7:0];
        din_BRAM32k_2  <= pair[15:8];
      end
    end
  end

  // Completion pulse, raised on the DONE -> IDLE edge.
  always_ff @(posedge clk) begin
    if (rst) layer_done <= 1'b0;
    else     layer_done <= (state_q == DONE);
  end

`ifdef WB_OVF_CHECK_EN
  // Sticky overflow flag, cleared by the next accepted layer.
  always_ff @(posedge clk) begin
    if (rst)                     ovf_err <= 1'b0;
    else if (start_ok)           ovf_err <= 1'b0;
    else if (wr_fire && ovf_hit) ovf_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl (default build, WB_OVF_CHECK_EN undefined).
// Reference model works on a byte queue and event schedule; a negedge process
// compares every DUT output to it each cycle.
module tb_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        layer_start;
  logic [3:0]  Layer;
  logic [11:0] base_addr;
  logic [15:0] out_count;
  logic        sum_valid;
  logic [7:0]  s [5];
  logic        sum_ready, we_BRAM32k, busy, layer_done;
  logic [11:0] addr_BRAM32k_1, addr_BRAM32k_2;
  logic [63:0] din_BRAM32k_1, din_BRAM32k_2;
`ifdef WB_OVF_CHECK_EN
  logic        ovf_err;
`endif

  wb_ctrl dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .Layer(Layer),
    .base_addr(base_addr), .out_count(out_count), .sum_valid(sum_valid),
    .sum1(s[0]), .sum2(s[1]), .sum3(s[2]), .sum4(s[3]), .sum5(s[4]),
    .sum_ready(sum_ready), .we_BRAM32k(we_BRAM32k),
    .addr_BRAM32k_1(addr_BRAM32k_1), .addr_BRAM32k_2(addr_BRAM32k_2),
    .din_BRAM32k_1(din_BRAM32k_1), .din_BRAM32k_2(din_BRAM32k_2),
    .busy(busy),
`ifdef WB_OVF_CHECK_EN
    .ovf_err(ovf_err),
`endif
    .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic [7:0]  mq[$];        // bytes accepted, not yet written
  int          wdue[$];      // edges on which a write is due
  bit          m_busy, m_run, m_acc;
  int          m_tot, m_out, m_base, m_k, m_done_edge;
  logic        exp_we, exp_done, exp_busy, exp_ready;
  logic [11:0] exp_a1, exp_a2;
  logic [63:0] exp_d1, exp_d2;
  bit          start_now, crossed;
  int          take, nb, entry;
  logic [127:0] d;

  initial begin
    m_busy = 0; m_run = 0; m_acc = 0; m_tot = 0; m_out = 0; m_base = 0; m_k = 0;
    m_done_edge = -1;
    exp_we = 0; exp_done = 0; exp_busy = 0; exp_ready = 0;
    exp_a1 = 0; exp_a2 = 0; exp_d1 = 0; exp_d2 = 0;
  end

  always @(posedge clk) begin
    cyc++;
    m_acc = 0;
    if (rst) begin
      mq.delete(); wdue.delete();
      m_busy = 0; m_run = 0; m_tot = 0; m_out = 0; m_k = 0; m_done_edge = -1;
      exp_we = 0; exp_done = 0; exp_busy = 0; exp_ready = 0;
      exp_a1 = 0; exp_a2 = 0; exp_d1 = 0; exp_d2 = 0;
    end else begin
      start_now = layer_start && !m_busy && !exp_done;
      exp_we = 0;
      exp_done = 0;
      if (m_busy && cyc == m_done_edge) begin
        m_busy = 0; m_run = 0; exp_done = 1;
      end
      if (wdue.size() > 0 && wdue[0] == cyc) begin
        void'(wdue.pop_front());
        nb = (mq.size() < 16) ? mq.size() : 16;
        d = '0;
        for (int i = 0; i < nb; i++) d[8*i +: 8] = mq.pop_front();
        exp_we = 1;
        exp_d1 = d[63:0];
        exp_d2 = d[127:64];
        exp_a1 = 12'((m_base + 2 * m_k) % 4096);
        exp_a2 = 12'((m_base + 2 * m_k + 1) % 4096);
        m_k++;
      end
      if (m_run && m_tot < m_out && sum_valid) begin
        m_acc = 1;
        take = (m_out - m_tot < 5) ? (m_out - m_tot) : 5;
        for (int i = 0; i < take; i++) mq.push_back(s[i]);
        crossed = ((m_tot + take) / 16) > (m_tot / 16);
        m_tot += take;
        if (crossed) wdue.push_back(cyc + 1);
        if (m_tot == m_out) begin
          entry = crossed ? cyc + 1 : cyc;
          if (m_out % 16 != 0) wdue.push_back(entry + 1);
          m_done_edge = entry + 2;
        end
      end
      if (start_now) begin
        mq.delete(); wdue.delete();
        m_base = int'(base_addr); m_out = int'(out_count);
        m_tot = 0; m_k = 0; m_busy = 1;
        if (m_out == 0) m_done_edge = cyc + 2;
        else            m_run = 1;
      end
      exp_busy  = m_busy;
      exp_ready = m_run && (m_tot < m_out);
    end
  end

  // ---------------- per-cycle compare + write capture ----------------
  logic [11:0] cap_a1[$], cap_a2[$];
  logic [63:0] cap_d1[$], cap_d2[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("sum_ready",  64'(sum_ready),      64'(exp_ready));
      chk("we",         64'(we_BRAM32k),     64'(exp_we));
      chk("addr_1",     64'(addr_BRAM32k_1), 64'(exp_a1));
      chk("addr_2",     64'(addr_BRAM32k_2), 64'(exp_a2));
      chk("din_1",      din_BRAM32k_1,       exp_d1);
      chk("din_2",      din_BRAM32k_2,       exp_d2);
      chk("busy",       64'(busy),           64'(exp_busy));
      chk("layer_done", 64'(layer_done),     64'(exp_done));
      if (we_BRAM32k === 1'b1) begin
        cap_a1.push_back(addr_BRAM32k_1); cap_a2.push_back(addr_BRAM32k_2);
        cap_d1.push_back(din_BRAM32k_1);  cap_d2.push_back(din_BRAM32k_2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_cap();
    cap_a1.delete(); cap_a2.delete(); cap_d1.delete(); cap_d2.delete();
  endtask

  task automatic start_layer(input logic [11:0] base, input logic [15:0] cnt);
    int g = 0;
    while ((busy || layer_done) && g < 200) begin @(negedge clk); g++; end
    chk("start_wait_timeout", 64'(g >= 200), 64'(0));
    clear_cap();
    layer_start = 1'b1; base_addr = base; out_count = cnt; Layer = 4'($urandom);
    @(negedge clk);
    layer_start = 1'b0;
  endtask

  task automatic feed(input bit cont, input bit seqb, input bit glitch);
    int g = 0;
    logic [7:0] seq = 8'h01;
    while (m_tot < m_out && g < 600) begin
      sum_valid = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++) s[i] = seqb ? seq + 8'(i) : 8'($urandom);
      if (glitch && g == 1) begin
        layer_start = 1'b1; base_addr = 12'($urandom); out_count = 16'($urandom);
      end
      @(negedge clk);
      layer_start = 1'b0;
      if (m_acc) seq = seq + 8'd5;
      g++;
    end
    chk("feed_timeout", 64'(g >= 600), 64'(0));
    g = 0;
    // Keep offering junk after the last byte; it must be ignored.
    while ((busy || layer_done) && g < 100) begin
      sum_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < 5; i++) s[i] = 8'($urandom);
      @(negedge clk);
      g++;
    end
    sum_valid = 1'b0;
    chk("layer_end_timeout", 64'(g >= 100), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; layer_start = 1'b0; Layer = 4'd0; base_addr = '0; out_count = '0;
    sum_valid = 1'b0;
    for (int i = 0; i < 5; i++) s[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_we", 64'(we_BRAM32k), 64'(0));
    chk("reset_ready", 64'(sum_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a layer with 10 bytes buffered.
    start_layer(12'h200, 16'd40);
    sum_valid = 1'b1;
    for (int i = 0; i < 5; i++) s[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    sum_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_we", 64'(we_BRAM32k), 64'(0));
    chk("midrst_nwrites", 64'(cap_a1.size()), 64'(0));
    @(negedge clk);

    // 16 bytes from a 0x01.. stream: single pair, extra bytes dropped.
    start_layer(12'h100, 16'd16);
    feed(1, 1, 0);
    chk("l16_nwrites", 64'(cap_a1.size()), 64'(1));
    if (cap_a1.size() == 1) begin
      chk("l16_addr1", 64'(cap_a1[0]), 64'h100);
      chk("l16_addr2", 64'(cap_a2[0]), 64'h101);
      chk("l16_din1", cap_d1[0], 64'h0807060504030201);
      chk("l16_din2", cap_d2[0], 64'h100F0E0D0C0B0A09);
    end

    // 7 bytes: tail-only flush, zero padded.
    start_layer(12'h040, 16'd7);
    feed(1, 1, 0);
    chk("l7_nwrites", 64'(cap_a1.size()), 64'(1));
    if (cap_a1.size() == 1) begin
      chk("l7_addr1", 64'(cap_a1[0]), 64'h040);
      chk("l7_din1", cap_d1[0], 64'h0007060504030201);
      chk("l7_din2", cap_d2[0], 64'h0);
    end

    // Empty layer: no write, done two edges after the start edge.
    start_layer(12'h010, 16'd0);
    @(negedge clk);
    chk("l0_done_early", 64'(layer_done), 64'(0));
    @(negedge clk);
    chk("l0_done", 64'(layer_done), 64'(1));
    feed(1, 0, 0);
    chk("l0_nwrites", 64'(cap_a1.size()), 64'(0));

    // Address wrap at the top of BRAM32k.
    start_layer(12'hFFE, 16'd48);
    feed(1, 0, 0);
    chk("wrap_nwrites", 64'(cap_a1.size()), 64'(3));
    if (cap_a1.size() == 3) begin
      chk("wrap_a1_0", 64'(cap_a1[0]), 64'hFFE);
      chk("wrap_a2_0", 64'(cap_a2[0]), 64'hFFF);
      chk("wrap_a1_1", 64'(cap_a1[1]), 64'h000);
      chk("wrap_a2_1", 64'(cap_a2[1]), 64'h001);
      chk("wrap_a1_2", 64'(cap_a1[2]), 64'h002);
    end

    // Sustained stream of 64 bytes, with a stray layer_start that must be ignored.
    start_layer(12'h300, 16'd64);
    feed(1, 0, 1);
    chk("l64_nwrites", 64'(cap_a1.size()), 64'(4));
    if (cap_a1.size() == 4)
      for (int k = 0; k < 4; k++) chk("l64_addr", 64'(cap_a1[k]), 64'(12'h300 + 12'(2 * k)));

    // Randomized layers with bursty valid.
    for (int r = 0; r < 12; r++) begin
      start_layer(12'($urandom_range(0, 4095)), 16'($urandom_range(1, 120)));
      feed(0, 0, (r % 3) == 0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
